// File: rtl/pipeline_exec_ctrl_pkg.sv
// rtl/pipeline_exec_ctrl_pkg.sv - opcode, command and FSM state constants for the exec controller
package pipeline_exec_ctrl_pkg;

  localparam logic [5:0] OP_NOP  = 6'b111110;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STEP = 2'b10;
  localparam logic [1:0] CMD_STOP = 2'b11;

  typedef logic [2:0] ec_state_t;

  localparam ec_state_t ST_IDLE   = 3'd0;
  localparam ec_state_t ST_RUN    = 3'd1;
  localparam ec_state_t ST_STEP   = 3'd2;
  localparam ec_state_t ST_DRAIN  = 3'd3;
  localparam ec_state_t ST_HALTED = 3'd4;

endpackage

// File: rtl/pipeline_exec_ctrl_if.sv
// rtl/pipeline_exec_ctrl_if.sv - debug command and pipeline control bundle for pipeline_exec_ctrl
interface pipeline_exec_ctrl_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
);
  logic             I_EC_CMD_VALID;
  logic [1:0]       I_EC_CMD;
  logic             O_EC_CMD_READY;
  logic [5:0]       I_EC_IF_OP;
  logic [PC_W-1:0]  I_EC_IF_PC;
  logic             I_EC_BP_ENA;
  logic [PC_W-1:0]  I_EC_BP_ADDR;
  logic             O_EC_PIPE_EN;
  logic             O_EC_FETCH_EN;
  logic             O_EC_INJECT_NOP;
  logic             O_EC_BUSY;
  logic             O_EC_HALTED;
  logic             O_EC_DONE;
  logic             O_EC_BP_HIT;
  logic [CNT_W-1:0] O_EC_CYCLES;

  modport master (
    output I_EC_CMD_VALID, I_EC_CMD, I_EC_IF_OP, I_EC_IF_PC, I_EC_BP_ENA, I_EC_BP_ADDR,
    input  O_EC_CMD_READY, O_EC_PIPE_EN, O_EC_FETCH_EN, O_EC_INJECT_NOP, O_EC_BUSY,
           O_EC_HALTED, O_EC_DONE, O_EC_BP_HIT, O_EC_CYCLES
  );

  modport slave (
    input  I_EC_CMD_VALID, I_EC_CMD, I_EC_IF_OP, I_EC_IF_PC, I_EC_BP_ENA, I_EC_BP_ADDR,
    output O_EC_CMD_READY, O_EC_PIPE_EN, O_EC_FETCH_EN, O_EC_INJECT_NOP, O_EC_BUSY,
           O_EC_HALTED, O_EC_DONE, O_EC_BP_HIT, O_EC_CYCLES
  );
endinterface

// File: rtl/pipeline_exec_ctrl_cycle_counter.sv
// rtl/pipeline_exec_ctrl_cycle_counter.sv - saturating cycle counter with enable and sync clear
module exec_cycle_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_exec_ctrl.sv
// rtl/pipeline_exec_ctrl.sv - run/step/halt sequencer for the 5-stage pipeline
// Optional breakpoint match enabled by defining EXEC_CTRL_BREAKPOINT_EN.
module pipeline_exec_ctrl
  import pipeline_exec_ctrl_pkg::*;
#(
  parameter int         PIPE_DEPTH = 5,
  parameter int         PC_W       = 32,
  parameter int         CNT_W      = 32,
  parameter logic [5:0] HALT_OP    = OP_HALT
) (
  input  logic                 I_CLK,
  input  logic                 I_RST,
  pipeline_exec_ctrl_if.slave  ec
);

  localparam int DW = (PIPE_DEPTH > 2) ? $clog2(PIPE_DEPTH) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(PIPE_DEPTH - 1);

  ec_state_t        state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic             done_q, done_d;
  logic             clr_cycles;
  logic             ready, pipe_en, fetch_en, inject_nop;
  logic             acc_run, acc_step, acc_stop, halt_seen, bp_match;
  logic [CNT_W-1:0] cycles;

  assign acc_run   = ec.I_EC_CMD_VALID && ready && (ec.I_EC_CMD == CMD_RUN);
  assign acc_step  = ec.I_EC_CMD_VALID && ready && (ec.I_EC_CMD == CMD_STEP);
  assign acc_stop  = ec.I_EC_CMD_VALID && ready && (ec.I_EC_CMD == CMD_STOP);
  assign halt_seen = (ec.I_EC_IF_OP == HALT_OP);

  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    done_d     = 1'b0;
    clr_cycles = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (acc_run) begin
          state_d = ST_RUN;
        end else if (acc_step) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (bp_match || halt_seen || acc_stop) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end
      end
      ST_STEP: begin
        // A stepped HALT drains instead; its completion comes from the drain.
        if (halt_seen) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q - DW'(1);
        if (drain_q <= DW'(1)) begin
          state_d = ST_HALTED;
          done_d  = 1'b1;
        end
      end
      ST_HALTED: begin
        if (acc_stop) begin
          state_d    = ST_IDLE;
          clr_cycles = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    ready      = 1'b0;
    pipe_en    = 1'b0;
    fetch_en   = 1'b0;
    inject_nop = 1'b0;
    case (state_q)
      ST_IDLE:   ready = 1'b1;
      ST_RUN: begin
        ready      = 1'b1;
        pipe_en    = 1'b1;
        fetch_en   = !bp_match;
        inject_nop = bp_match;
      end
      ST_STEP: begin
        pipe_en  = 1'b1;
        fetch_en = 1'b1;
      end
      ST_DRAIN: begin
        pipe_en    = 1'b1;
        inject_nop = 1'b1;
      end
      ST_HALTED: ready = 1'b1;
      default:   ready = 1'b0;
    endcase
  end

`ifdef EXEC_CTRL_BREAKPOINT_EN
  logic first_run_q, first_run_d;
  logic bp_pend_q, bp_pend_d;
  logic bp_hit_q, bp_hit_d;

  // The first RUN cycle after a resume may sit on the breakpoint PC; skip it.
  assign bp_match = (state_q == ST_RUN) && !first_run_q && ec.I_EC_BP_ENA &&
                    (ec.I_EC_IF_PC == ec.I_EC_BP_ADDR);

  always_comb begin
    first_run_d = (state_q == ST_IDLE) && acc_run;
    bp_pend_d   = bp_pend_q;
    bp_hit_d    = bp_hit_q;
    if ((state_q != ST_DRAIN) && (state_d == ST_DRAIN)) begin
      bp_pend_d = bp_match;
    end
    if ((state_q == ST_DRAIN) && (state_d == ST_HALTED)) begin
      bp_hit_d = bp_pend_q;
    end else if (clr_cycles) begin
      bp_hit_d = 1'b0;
    end
  end

  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      first_run_q <= 1'b0;
      bp_pend_q   <= 1'b0;
      bp_hit_q    <= 1'b0;
    end else begin
      first_run_q <= first_run_d;
      bp_pend_q   <= bp_pend_d;
      bp_hit_q    <= bp_hit_d;
    end
  end

  assign ec.O_EC_BP_HIT = bp_hit_q;
`else
  logic [2*PC_W:0] unused_bp;
  assign unused_bp      = {ec.I_EC_BP_ENA, ec.I_EC_BP_ADDR, ec.I_EC_IF_PC};
  assign bp_match       = 1'b0;
  assign ec.O_EC_BP_HIT = 1'b0;
`endif

  exec_cycle_counter #(.CNT_W(CNT_W)) u_cycles (
    .clk_i (I_CLK),
    .rst_i (I_RST),
    .en_i  (pipe_en),
    .clr_i (clr_cycles),
    .cnt_o (cycles)
  );

  assign ec.O_EC_CMD_READY  = ready;
  assign ec.O_EC_PIPE_EN    = pipe_en;
  assign ec.O_EC_FETCH_EN   = fetch_en;
  assign ec.O_EC_INJECT_NOP = inject_nop;
  assign ec.O_EC_BUSY       = (state_q == ST_RUN) || (state_q == ST_STEP) || (state_q == ST_DRAIN);
  assign ec.O_EC_HALTED     = (state_q == ST_HALTED);
  assign ec.O_EC_DONE       = done_q;
  assign ec.O_EC_CYCLES     = cycles;

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// tb/tb_pipeline_exec_ctrl.sv - self-checking bench for pipeline_exec_ctrl against a behavioural model
module tb_pipeline_exec_ctrl;

  localparam int PIPE_DEPTH = 5;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_NOPB = 6'b111110;
  localparam logic [5:0] OP_HLT  = 6'b111111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pipeline_exec_ctrl_if #(.PC_W(32), .CNT_W(32)) ec ();

  pipeline_exec_ctrl #(.PIPE_DEPTH(PIPE_DEPTH), .PC_W(32), .CNT_W(32)) dut (
    .I_CLK (clk),
    .I_RST (rst),
    .ec    (ec)
  );

  typedef enum {M_IDLE, M_RUN, M_STEP, M_DRAIN, M_HALTED} mode_t;
  mode_t           m_mode;
  int              m_left;
  logic            m_done;
  longint unsigned m_cycles;
  logic            m_v;
  logic [1:0]      m_c;
  logic [5:0]      m_op;

  // {ready, pipe_en, fetch_en, inject_nop, busy, halted, done, bp_hit}
  function automatic logic [7:0] m_out();
    logic working;
    working = (m_mode == M_RUN) || (m_mode == M_STEP) || (m_mode == M_DRAIN);
    return {(m_mode == M_IDLE) || (m_mode == M_RUN) || (m_mode == M_HALTED),
            working,
            (m_mode == M_RUN) || (m_mode == M_STEP),
            (m_mode == M_DRAIN),
            working,
            (m_mode == M_HALTED),
            m_done,
            1'b0};
  endfunction

  function automatic logic [7:0] dut_out();
    return {ec.O_EC_CMD_READY, ec.O_EC_PIPE_EN, ec.O_EC_FETCH_EN, ec.O_EC_INJECT_NOP,
            ec.O_EC_BUSY, ec.O_EC_HALTED, ec.O_EC_DONE, ec.O_EC_BP_HIT};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_left = 0; m_done = 1'b0; m_cycles = 0;
  endtask

  task automatic do_reset();
    ec.I_EC_CMD_VALID = 1'b0; ec.I_EC_CMD = 2'b00; ec.I_EC_IF_OP = OP_NOPB;
    ec.I_EC_IF_PC = '0; ec.I_EC_BP_ENA = 1'b0; ec.I_EC_BP_ADDR = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic drive(input logic v, input logic [1:0] c, input logic [5:0] op);
    ec.I_EC_CMD_VALID = v; ec.I_EC_CMD = c; ec.I_EC_IF_OP = op;
    m_v = v; m_c = c; m_op = op;
    @(negedge clk);
  endtask

  task automatic advance();
    logic acc;
    logic [7:0] o;
    o = m_out();
    acc = m_v && o[7];
    if (o[6] && m_cycles != 64'hFFFF_FFFF) m_cycles++;
    m_done = 1'b0;
    case (m_mode)
      M_IDLE:   if (acc && m_c == 2'b01) m_mode = M_RUN;
                else if (acc && m_c == 2'b10) m_mode = M_STEP;
      M_RUN:    if (m_op == OP_HLT || (acc && m_c == 2'b11)) begin
                  m_mode = M_DRAIN; m_left = PIPE_DEPTH - 1;
                end
      M_STEP:   if (m_op == OP_HLT) begin
                  m_mode = M_DRAIN; m_left = PIPE_DEPTH - 1;
                end else begin
                  m_mode = M_IDLE; m_done = 1'b1;
                end
      M_DRAIN:  begin
                  m_left--;
                  if (m_left == 0) begin m_mode = M_HALTED; m_done = 1'b1; end
                end
      M_HALTED: if (acc && m_c == 2'b11) begin m_mode = M_IDLE; m_cycles = 0; end
      default:  m_mode = M_IDLE;
    endcase
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    drive(1'b0, 2'b00, OP_ADDI);
    n_vec++;
    if (dut_out() !== 8'b1000_0000) begin
      n_err++; $display("FAIL reset_outputs got %b want %b", dut_out(), 8'b1000_0000);
    end
    n_vec++;
    if (ec.O_EC_CYCLES !== 32'd0) begin
      n_err++; $display("FAIL reset_cycles got %0d want 0", ec.O_EC_CYCLES);
    end
    advance();
  endtask

  task automatic test_run_halt();
    int fetches = 0, drains = 0;
    do_reset();
    drive(1'b1, 2'b01, OP_ADDI);
    advance();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 2'b00, (i == 4) ? OP_HLT : OP_ADDI);
      n_vec++;
      if (dut_out() !== m_out()) begin
        n_err++; $display("FAIL run_cycle%0d got %b want %b", i, dut_out(), m_out());
      end
      if (ec.O_EC_FETCH_EN) fetches++;
      advance();
    end
    for (int i = 0; i < 10 && !ec.O_EC_HALTED; i++) begin
      drive(1'b0, 2'b00, OP_NOPB);
      n_vec++;
      if (dut_out() !== m_out()) begin
        n_err++; $display("FAIL drain_cycle%0d got %b want %b", i, dut_out(), m_out());
      end
      if (ec.O_EC_INJECT_NOP && !ec.O_EC_HALTED) drains++;
      if (!ec.O_EC_HALTED) advance();
    end
    n_vec++;
    if (fetches != 4 || drains != 4) begin
      n_err++; $display("FAIL run_halt_counts got fetch=%0d drain=%0d want 4/4", fetches, drains);
    end
    n_vec++;
    if (ec.O_EC_HALTED !== 1'b1 || ec.O_EC_DONE !== 1'b1 || ec.O_EC_CYCLES !== 32'd8) begin
      n_err++; $display("FAIL run_halt_end got halted=%b done=%b cycles=%0d want 1 1 8",
                        ec.O_EC_HALTED, ec.O_EC_DONE, ec.O_EC_CYCLES);
    end
    advance();
    drive(1'b0, 2'b00, OP_ADDI);
    n_vec++;
    if (ec.O_EC_DONE !== 1'b0) begin
      n_err++; $display("FAIL run_halt_done_pulse got %b want 0", ec.O_EC_DONE);
    end
    advance();
  endtask

  task automatic test_step();
    do_reset();
    drive(1'b1, 2'b10, OP_ADDI);
    advance();
    drive(1'b1, 2'b01, OP_ADDI);
    n_vec++;
    if (ec.O_EC_CMD_READY !== 1'b0 || ec.O_EC_PIPE_EN !== 1'b1 || ec.O_EC_FETCH_EN !== 1'b1) begin
      n_err++; $display("FAIL step_active got %b want ready=0 pipe=1 fetch=1", dut_out());
    end
    advance();
    drive(1'b0, 2'b00, OP_ADDI);
    n_vec++;
    if (dut_out() !== 8'b1000_0010 || ec.O_EC_CYCLES !== 32'd1) begin
      n_err++; $display("FAIL step_done got %b cycles=%0d want 10000010 cycles=1",
                        dut_out(), ec.O_EC_CYCLES);
    end
    advance();
    drive(1'b0, 2'b00, OP_ADDI);
    n_vec++;
    if (dut_out() !== 8'b1000_0000) begin
      n_err++; $display("FAIL step_idle_after got %b want 10000000", dut_out());
    end
    advance();
  endtask

  task automatic test_stop_and_halt();
    int drains = 0, dones = 0;
    do_reset();
    drive(1'b1, 2'b01, OP_ADDI); advance();
    drive(1'b0, 2'b00, OP_ADDI); advance();
    drive(1'b1, 2'b11, OP_HLT);  advance();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 2'b00, OP_HLT);
      n_vec++;
      if (dut_out() !== m_out()) begin
        n_err++; $display("FAIL stop_halt_cycle%0d got %b want %b", i, dut_out(), m_out());
      end
      if (ec.O_EC_INJECT_NOP) drains++;
      if (ec.O_EC_DONE) dones++;
      advance();
    end
    n_vec++;
    if (drains != 4 || dones != 1) begin
      n_err++; $display("FAIL stop_halt_once got drain=%0d done=%0d want 4/1", drains, dones);
    end
  endtask

  task automatic test_halted_cmds();
    drive(1'b1, 2'b01, OP_ADDI);
    n_vec++;
    if (ec.O_EC_CMD_READY !== 1'b1 || ec.O_EC_HALTED !== 1'b1) begin
      n_err++; $display("FAIL halted_run_ready got %b want ready=1 halted=1", dut_out());
    end
    advance();
    drive(1'b1, 2'b10, OP_ADDI);
    n_vec++;
    if (dut_out() !== 8'b1000_0100 || ec.O_EC_CYCLES !== 32'd6) begin
      n_err++; $display("FAIL halted_ignore got %b cycles=%0d want 10000100 cycles=6",
                        dut_out(), ec.O_EC_CYCLES);
    end
    advance();
    drive(1'b1, 2'b11, OP_ADDI); advance();
    drive(1'b0, 2'b00, OP_ADDI);
    n_vec++;
    if (dut_out() !== 8'b1000_0000 || ec.O_EC_CYCLES !== 32'd0) begin
      n_err++; $display("FAIL halted_stop got %b cycles=%0d want 10000000 cycles=0",
                        dut_out(), ec.O_EC_CYCLES);
    end
    advance();
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    drive(1'b1, 2'b01, OP_ADDI); advance();
    drive(1'b0, 2'b00, OP_ADDI); advance();
    drive(1'b1, 2'b11, OP_ADDI); advance();
    drive(1'b0, 2'b00, OP_ADDI); advance();
    rst = 1'b1;
    #1;
    n_vec++;
    if (dut_out() !== 8'b1000_0000 || ec.O_EC_CYCLES !== 32'd0) begin
      n_err++; $display("FAIL reset_mid_drain got %b cycles=%0d want 10000000 cycles=0",
                        dut_out(), ec.O_EC_CYCLES);
    end
    @(negedge clk);
    n_vec++;
    if (dut_out() !== 8'b1000_0000) begin
      n_err++; $display("FAIL reset_mid_drain_next got %b want 10000000", dut_out());
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    logic [5:0] op;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      op = ($urandom_range(0, 7) == 0) ? OP_HLT : 6'($urandom_range(0, 62));
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), op);
      n_vec++;
      if (dut_out() !== m_out() || ec.O_EC_CYCLES !== m_cycles[31:0]) begin
        n_err++; $display("FAIL random_cycle%0d got %b cycles=%0d want %b cycles=%0d",
                          i, dut_out(), ec.O_EC_CYCLES, m_out(), m_cycles);
      end
      advance();
    end
  endtask

`ifdef EXEC_CTRL_BREAKPOINT_EN
  task automatic bp_cycle(input logic v, input logic [1:0] c, input logic [31:0] pc);
    ec.I_EC_CMD_VALID = v; ec.I_EC_CMD = c; ec.I_EC_IF_OP = OP_ADDI; ec.I_EC_IF_PC = pc;
    @(negedge clk);
  endtask

  task automatic test_breakpoint();
    do_reset();
    ec.I_EC_BP_ENA = 1'b1; ec.I_EC_BP_ADDR = 32'h10;
    bp_cycle(1'b1, 2'b01, 32'h4);  @(posedge clk); #1;
    bp_cycle(1'b0, 2'b00, 32'h8);  @(posedge clk); #1;
    bp_cycle(1'b0, 2'b00, 32'hC);  @(posedge clk); #1;
    bp_cycle(1'b0, 2'b00, 32'h10);
    n_vec++;
    if (ec.O_EC_FETCH_EN !== 1'b0 || ec.O_EC_INJECT_NOP !== 1'b1 || ec.O_EC_PIPE_EN !== 1'b1) begin
      n_err++; $display("FAIL bp_match_cycle got %b want fetch=0 inject=1 pipe=1", dut_out());
    end
    for (int i = 0; i < 8 && !ec.O_EC_HALTED; i++) begin
      @(posedge clk); #1;
      bp_cycle(1'b0, 2'b00, 32'h10);
    end
    n_vec++;
    if (ec.O_EC_HALTED !== 1'b1 || ec.O_EC_BP_HIT !== 1'b1 || ec.O_EC_DONE !== 1'b1) begin
      n_err++; $display("FAIL bp_halt got %b want halted=1 bp_hit=1 done=1", dut_out());
    end
    @(posedge clk); #1;
    bp_cycle(1'b1, 2'b11, 32'h10); @(posedge clk); #1;
    bp_cycle(1'b1, 2'b01, 32'h10);
    n_vec++;
    if (ec.O_EC_BP_HIT !== 1'b0) begin
      n_err++; $display("FAIL bp_clear got %b want 0", ec.O_EC_BP_HIT);
    end
    @(posedge clk); #1;
    bp_cycle(1'b0, 2'b00, 32'h10);
    n_vec++;
    if (ec.O_EC_FETCH_EN !== 1'b1 || ec.O_EC_INJECT_NOP !== 1'b0) begin
      n_err++; $display("FAIL bp_resume got %b want fetch=1 inject=0", dut_out());
    end
    @(posedge clk); #1;
    bp_cycle(1'b0, 2'b00, 32'h14);
    n_vec++;
    if (ec.O_EC_BUSY !== 1'b1 || ec.O_EC_FETCH_EN !== 1'b1) begin
      n_err++; $display("FAIL bp_no_rehit got %b want busy=1 fetch=1", dut_out());
    end
    @(posedge clk); #1;
    do_reset();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_run_halt();
    test_step();
    test_stop_and_halt();
    test_halted_cmds();
    test_reset_mid_drain();
    test_random();
`ifdef EXEC_CTRL_BREAKPOINT_EN
    test_breakpoint();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
